// File: rtl/cpu_clk_sched.sv
// cpu_clk_sched
//   Clock-enable scheduler for the CPU / branch-predictor datapath. It emits a
//   registered one-cycle enable pulse (tick) that is sequenced by run (level),
//   single-step, fixed-length burst and halt commands. The tick period comes
//   from a divisor that can be reloaded at runtime.
// Ports
//   clk, reset      system clock; synchronous active-high reset
//   run             level, continuous ticking request
//   step_req        pulse, request exactly one tick
//   burst_start     pulse, request burst_len ticks (burst_len sampled with it)
//   halt            pulse, abort any activity
//   div_load        pulse, load div_value (0 is treated as 1)
//   tick            registered one-cycle clock enable
//   busy            state != IDLE
//   state_o         IDLE=0 RUN=1 BURST=2 STEP=3
//   remaining       ticks still owed in BURST, else 0
module cpu_clk_sched #(
    parameter int unsigned DIV_DEFAULT = 50_000_000,
    parameter int          CNT_W       = 32,
    parameter int          BURST_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               step_req,
    input  logic               burst_start,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               halt,
    input  logic               div_load,
    input  logic [CNT_W-1:0]   div_value,
    output logic               tick,
    output logic               busy,
    output logic [1:0]         state_o,
    output logic [BURST_W-1:0] remaining
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2,
        STEP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
    // A zero default divisor would make the wrap compare underflow.
    localparam logic [CNT_W-1:0]   DIV_RST   = (DIV_DEFAULT == 0) ? CNT_ONE : CNT_W'(DIV_DEFAULT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [BURST_W-1:0] remaining_q, remaining_d;
    logic               tick_q, tick_d;
    logic               wrap;

    // div_q is never 0, so div_q-1 cannot underflow.
    assign wrap = (count_q == div_q - CNT_ONE);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        div_d       = div_q;
        remaining_d = remaining_q;
        tick_d      = 1'b0;

        case (state_q)
            IDLE: begin
                count_d     = '0;
                remaining_d = '0;
                // run wins over burst over step; losers are simply dropped
                if (run) begin
                    state_d = RUN;
                end else if (burst_start && (burst_len != '0)) begin
                    state_d     = BURST;
                    remaining_d = burst_len;
                end else if (step_req) begin
                    state_d = STEP;
                    tick_d  = 1'b1;
                end
            end
            RUN: begin
                count_d = wrap ? '0 : count_q + CNT_ONE;
                tick_d  = wrap;   // a wrap on the exit cycle still ticks
                if (!run) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            BURST: begin
                count_d = wrap ? '0 : count_q + CNT_ONE;
                tick_d  = wrap;
                if (wrap) begin
                    remaining_d = remaining_q - BURST_ONE;
                    // last tick and IDLE land together, so busy drops with it
                    if (remaining_q == BURST_ONE) begin
                        state_d = IDLE;
                        count_d = '0;
                    end
                end
            end
            STEP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Divisor reload restarts the period but leaves state/remaining alone.
        if (div_load) begin
            div_d   = (div_value == '0) ? CNT_ONE : div_value;
            count_d = '0;
        end

        // halt overrides everything, including a coincident wrap or reload.
        if (halt) begin
            state_d     = IDLE;
            count_d     = '0;
            remaining_d = '0;
            tick_d      = 1'b0;
            div_d       = div_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            div_q       <= DIV_RST;
            remaining_q <= '0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            div_q       <= div_d;
            remaining_q <= remaining_d;
            tick_q      <= tick_d;
        end
    end

    assign tick      = tick_q;
    assign busy      = (state_q != IDLE);
    assign state_o   = state_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_cpu_clk_sched.sv
// Bench for cpu_clk_sched: directed scenarios with hand-derived expectations,
// then randomized commands checked against a period-arithmetic reference model.
module tb_cpu_clk_sched;

    localparam int CNT_W   = 32;
    localparam int BURST_W = 16;
    localparam int DIV_DEF = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               run;
    logic               step_req;
    logic               burst_start;
    logic [BURST_W-1:0] burst_len;
    logic               halt;
    logic               div_load;
    logic [CNT_W-1:0]   div_value;
    logic               tick;
    logic               busy;
    logic [1:0]         state_o;
    logic [BURST_W-1:0] remaining;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_clk_sched #(
        .DIV_DEFAULT(DIV_DEF),
        .CNT_W      (CNT_W),
        .BURST_W    (BURST_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step_req   (step_req),
        .burst_start(burst_start),
        .burst_len  (burst_len),
        .halt       (halt),
        .div_load   (div_load),
        .div_value  (div_value),
        .tick       (tick),
        .busy       (busy),
        .state_o    (state_o),
        .remaining  (remaining)
    );

    task automatic clear_inputs();
        run = 0; step_req = 0; burst_start = 0; burst_len = '0;
        halt = 0; div_load = 0; div_value = '0;
    endtask

    // Leaves the bench at a negedge with reset released; inputs set now are
    // sampled at the first out-of-reset edge.
    task automatic do_reset();
        reset = 1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic load_div(input int v);
        div_load  = 1;
        div_value = CNT_W'(v);
        @(negedge clk);
        div_load  = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (tick !== 1'b0)       begin bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (state_o !== 2'd0)    begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        total++; if (remaining !== '0)    begin bad++; $display("FAIL reset_remaining got=%0d exp=0", remaining); end
    endtask

    task automatic test_run();
        logic exp_t;
        int   n;
        do_reset();
        run = 1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            exp_t = (k == 5 || k == 9 || k == 13);
            total++; if (tick !== exp_t) begin bad++; $display("FAIL run_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
            total++; if (state_o !== 2'd1) begin bad++; $display("FAIL run_state k=%0d got=%0d exp=1", k, state_o); end
        end
        run = 0;
        n = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (tick) n++;
            if (k == 1) begin
                total++; if (state_o !== 2'd0) begin bad++; $display("FAIL run_stop_state got=%0d exp=0", state_o); end
                total++; if (busy !== 1'b0)    begin bad++; $display("FAIL run_stop_busy got=%b exp=0", busy); end
            end
        end
        total++; if (n !== 0) begin bad++; $display("FAIL run_stop_ticks got=%0d exp=0", n); end
    endtask

    task automatic test_burst();
        logic exp_t, exp_b;
        int   exp_r;
        do_reset();
        load_div(3);
        burst_start = 1;
        burst_len   = BURST_W'(3);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            burst_start = 0;
            exp_t = (k == 4 || k == 7 || k == 10);
            exp_r = (k < 4) ? 3 : (k < 7) ? 2 : (k < 10) ? 1 : 0;
            exp_b = (k < 10);
            total++; if (tick !== exp_t)              begin bad++; $display("FAIL burst_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
            total++; if (remaining !== BURST_W'(exp_r)) begin bad++; $display("FAIL burst_remaining k=%0d got=%0d exp=%0d", k, remaining, exp_r); end
            total++; if (busy !== exp_b)              begin bad++; $display("FAIL burst_busy k=%0d got=%b exp=%b", k, busy, exp_b); end
        end
    endtask

    task automatic test_step();
        logic exp_t;
        // divisor is still 3 from the burst scenario
        step_req = 1;
        @(negedge clk);
        step_req = 0;
        total++; if (tick !== 1'b1)    begin bad++; $display("FAIL step_tick got=%b exp=1", tick); end
        total++; if (state_o !== 2'd3) begin bad++; $display("FAIL step_state got=%0d exp=3", state_o); end
        @(negedge clk);
        total++; if (tick !== 1'b0)    begin bad++; $display("FAIL step_after_tick got=%b exp=0", tick); end
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL step_after_state got=%0d exp=0", state_o); end
        run = 1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_t = (k == 4 || k == 7);
            total++; if (tick !== exp_t)   begin bad++; $display("FAIL step_in_run_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
            total++; if (state_o !== 2'd1) begin bad++; $display("FAIL step_in_run_state k=%0d got=%0d exp=1", k, state_o); end
            step_req = (k == 2);
        end
        run = 0;
        repeat (2) @(negedge clk);
        burst_start = 1;
        burst_len   = '0;
        @(negedge clk);
        burst_start = 0;
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL burst_zero_state got=%0d exp=0", state_o); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL burst_zero_busy got=%b exp=0", busy); end
    endtask

    task automatic test_halt_reset();
        logic exp_t;
        do_reset();
        load_div(3);
        burst_start = 1;
        burst_len   = BURST_W'(3);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            burst_start = 0;
            halt        = (k == 6);   // cycle 6 is a wrap cycle
            exp_t = (k == 4);
            total++; if (tick !== exp_t) begin bad++; $display("FAIL halt_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
        end
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL halt_state got=%0d exp=0", state_o); end
        total++; if (remaining !== '0) begin bad++; $display("FAIL halt_remaining got=%0d exp=0", remaining); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL halt_busy got=%b exp=0", busy); end
        run = 1;
        repeat (3) @(negedge clk);
        reset = 1;   // cycle 3 would otherwise wrap
        run   = 0;
        @(negedge clk);
        total++; if (tick !== 1'b0)    begin bad++; $display("FAIL midrun_reset_tick got=%b exp=0", tick); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL midrun_reset_busy got=%b exp=0", busy); end
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL midrun_reset_state got=%0d exp=0", state_o); end
        total++; if (remaining !== '0) begin bad++; $display("FAIL midrun_reset_remaining got=%0d exp=0", remaining); end
        reset = 0;
    endtask

    task automatic test_div_load();
        logic exp_t;
        do_reset();
        run = 1;
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            exp_t = (k == 5 || k == 9 || (k >= 12 && k <= 17) || k == 22);
            total++; if (tick !== exp_t) begin bad++; $display("FAIL div_load_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
            div_load  = (k == 10 || k == 16);
            div_value = (k == 16) ? CNT_W'(5) : '0;
        end
        run = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_priority();
        do_reset();
        run         = 1;
        burst_start = 1;
        burst_len   = BURST_W'(5);
        step_req    = 1;
        @(negedge clk);
        burst_start = 0;
        step_req    = 0;
        total++; if (state_o !== 2'd1) begin bad++; $display("FAIL prio_state got=%0d exp=1", state_o); end
        total++; if (remaining !== '0) begin bad++; $display("FAIL prio_remaining got=%0d exp=0", remaining); end
        total++; if (tick !== 1'b0)    begin bad++; $display("FAIL prio_tick got=%b exp=0", tick); end
        run = 0;
        repeat (2) @(negedge clk);
    endtask

    // Reference: the counter is never stored. An active mode remembers the
    // cycle its period started (anchor); a wrap happens in cycle x whenever
    // x+1 is a whole number of periods past the anchor.
    task automatic test_random();
        int   mstate, mdiv, anchor, owed;
        logic mtick, wrap, r_run;
        mstate = 0; mdiv = DIV_DEF; anchor = 0; owed = 0; mtick = 0; r_run = 0;
        do_reset();
        for (int x = 0; x < 3000; x++) begin
            if ($urandom_range(39) == 0) r_run = ~r_run;
            run         = r_run;
            reset       = ($urandom_range(499) == 0);
            halt        = ($urandom_range(59) == 0);
            step_req    = ($urandom_range(9) == 0);
            burst_start = ($urandom_range(9) == 0);
            burst_len   = BURST_W'($urandom_range(5));
            div_load    = !halt && !reset && ($urandom_range(29) == 0);
            div_value   = CNT_W'($urandom_range(6));

            wrap  = (mstate == 1 || mstate == 2) && (((x - anchor + 1) % mdiv) == 0);
            mtick = 0;
            if (reset) begin
                mstate = 0; mdiv = DIV_DEF; owed = 0;
            end else if (halt) begin
                mstate = 0; owed = 0;
            end else begin
                if (mstate == 0) begin
                    if (run) begin
                        mstate = 1; anchor = x + 1;
                    end else if (burst_start && burst_len != 0) begin
                        mstate = 2; anchor = x + 1; owed = int'(burst_len);
                    end else if (step_req) begin
                        mstate = 3; mtick = 1;
                    end
                end else if (mstate == 1) begin
                    mtick = wrap;
                    if (!run) mstate = 0;
                end else if (mstate == 2) begin
                    mtick = wrap;
                    if (wrap) begin
                        owed--;
                        if (owed == 0) mstate = 0;
                    end
                end else begin
                    mstate = 0;
                end
                if (div_load) begin
                    mdiv   = (div_value == 0) ? 1 : int'(div_value);
                    anchor = x + 1;
                end
            end

            @(negedge clk);
            total++; if (tick !== mtick)                 begin bad++; $display("FAIL rand_tick x=%0d got=%b exp=%b", x, tick, mtick); end
            total++; if (state_o !== 2'(mstate))         begin bad++; $display("FAIL rand_state x=%0d got=%0d exp=%0d", x, state_o, mstate); end
            total++; if (busy !== (mstate != 0))         begin bad++; $display("FAIL rand_busy x=%0d got=%b exp=%b", x, busy, mstate != 0); end
            total++; if (remaining !== BURST_W'(owed))   begin bad++; $display("FAIL rand_remaining x=%0d got=%0d exp=%0d", x, remaining, owed); end
        end
        reset = 0;
        clear_inputs();
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_run();
        test_burst();
        test_step();
        test_halt_reset();
        test_div_load();
        test_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
